fac: RTL and testbench

Single-bit full-adder cell used as the ripple element of the multi-bit adders (e.g. the 2-bit `add2b` chain: bit 0 carry-out feeds bit 1 carry-in). It computes sum and carry combinationally so chains settle within one evaluation window without pipeline bubbles. It also exposes propagate/generate terms for lookahead use and a registered copy of its results for clocked consumers.

---
 rtl/fac.sv | 44 ++++
 tb/tb_fac.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fac.sv
// Full-adder cell: combinational sum/carry built from two half adders, with
// propagate/generate exposed for lookahead and a registered copy of sum/carry.
module fac (
    input  logic clk,
    input  logic rst_n,
    input  logic x,
    input  logic y,
    input  logic cIn,
    output logic z,
    output logic cOut,
    output logic p,
    output logic g,
    output logic z_q,
    output logic cOut_q
);

    logic z_d;
    logic cout_d;

    // First half adder on x/y, second on p/cIn; the carries are ORed.
    always_comb begin
        p    = x ^ y;
        g    = x & y;
        z    = p ^ cIn;
        cOut = g | (p & cIn);
    end

    // Next state of the result registers; reset forces zeros.
    always_comb begin
        z_d    = z;
        cout_d = cOut;
        if (!rst_n) begin
            z_d    = 1'b0;
            cout_d = 1'b0;
        end
    end

    // Result registers. rst_n is sampled only at the clock edge.
    always_ff @(posedge clk) begin
        z_q    <= z_d;
        cOut_q <= cout_d;
    end

endmodule

// File: tb/tb_fac.sv
// Directed bench for fac: truth table, 2-bit ripple chain, register latency
// and synchronous reset behaviour.
module tb_fac;

    logic clk;
    logic rst_n;
    logic x, y, cIn;
    logic z, cOut, p, g, z_q, cOut_q;

    // 2-bit ripple chain built from two cells.
    logic [1:0] ax, ay;
    logic       acin;
    logic [1:0] az;
    logic       c0, c1;
    logic       p0, g0, p1, g1, zq0, cq0, zq1, cq1;

    int checks;
    int fails;

    fac u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .x      (x),
        .y      (y),
        .cIn    (cIn),
        .z      (z),
        .cOut   (cOut),
        .p      (p),
        .g      (g),
        .z_q    (z_q),
        .cOut_q (cOut_q)
    );

    fac u_bit0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .x      (ax[0]),
        .y      (ay[0]),
        .cIn    (acin),
        .z      (az[0]),
        .cOut   (c0),
        .p      (p0),
        .g      (g0),
        .z_q    (zq0),
        .cOut_q (cq0)
    );

    fac u_bit1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .x      (ax[1]),
        .y      (ay[1]),
        .cIn    (c0),
        .z      (az[1]),
        .cOut   (c1),
        .p      (p1),
        .g      (g1),
        .z_q    (zq1),
        .cOut_q (cq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] tz, tc, tp, tg;
        logic [2:0] want;
        checks = 0;
        fails  = 0;
        // Truth tables indexed by {x,y,cIn}.
        tz = 8'b1001_0110;
        tc = 8'b1110_1000;
        tp = 8'b0011_1100;
        tg = 8'b1100_0000;

        rst_n = 1'b0;
        x = 1'b0; y = 1'b0; cIn = 1'b0;
        ax = 2'b00; ay = 2'b00; acin = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_z_q", {7'd0, z_q}, 8'd0);
        chk("reset_cOut_q", {7'd0, cOut_q}, 8'd0);

        // Combinational outputs stay live while reset is held.
        x = 1'b1; y = 1'b0; cIn = 1'b1;
        #1;
        chk("comb_in_reset_z", {7'd0, z}, 8'd0);
        chk("comb_in_reset_cOut", {7'd0, cOut}, 8'd1);

        // Exhaustive truth table.
        for (int i = 0; i < 8; i++) begin
            {x, y, cIn} = i[2:0];
            #2;
            chk($sformatf("tt_z_%0d", i), {7'd0, z}, {7'd0, tz[i]});
            chk($sformatf("tt_cOut_%0d", i), {7'd0, cOut}, {7'd0, tc[i]});
            chk($sformatf("tt_p_%0d", i), {7'd0, p}, {7'd0, tp[i]});
            chk($sformatf("tt_g_%0d", i), {7'd0, g}, {7'd0, tg[i]});
        end

        // Hand-computed ripple cases.
        ax = 2'b11; ay = 2'b01; acin = 1'b0;
        #10;
        chk("ripple_3_1_0", {5'd0, c1, az}, 8'b100);
        ax = 2'b11; ay = 2'b11; acin = 1'b1;
        #10;
        chk("ripple_3_3_1", {5'd0, c1, az}, 8'b111);

        // Full 2-bit sweep against integer addition.
        for (int v = 0; v < 32; v++) begin
            {ax, ay, acin} = v[4:0];
            #10;
            want = {1'b0, ax} + {1'b0, ay} + {2'b00, acin};
            chk($sformatf("ripple_sweep_%0d", v), {5'd0, c1, az}, {5'd0, want});
        end

        // Register latency, starting from cleared registers.
        @(negedge clk);
        rst_n = 1'b1;
        x = 1'b0; y = 1'b0; cIn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        x = 1'b1; y = 1'b1; cIn = 1'b0;
        #1;
        chk("lat1_before_edge", {6'd0, z_q, cOut_q}, 8'b00);
        @(posedge clk);
        #1;
        chk("lat1_after_edge", {6'd0, z_q, cOut_q}, 8'b01);
        @(negedge clk);
        x = 1'b0; y = 1'b0; cIn = 1'b1;
        #1;
        chk("lat2_before_edge", {6'd0, z_q, cOut_q}, 8'b01);
        @(posedge clk);
        #1;
        chk("lat2_after_edge", {6'd0, z_q, cOut_q}, 8'b10);

        // Reset held across one edge with all inputs high.
        @(negedge clk);
        x = 1'b1; y = 1'b1; cIn = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_regs", {6'd0, z_q, cOut_q}, 8'b00);
        chk("rst_comb", {6'd0, z, cOut}, 8'b11);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release", {6'd0, z_q, cOut_q}, 8'b11);

        // Low pulse strictly between edges must be ignored.
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("glitch_ignored", {6'd0, z_q, cOut_q}, 8'b11);

        // Low across an edge clears the registers.
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_op", {6'd0, z_q, cOut_q}, 8'b00);
        chk("rst_mid_op_comb", {6'd0, z, cOut}, 8'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
